// File: rtl/ps2_keyboard_if.sv
// PS/2 keyboard port bundle: raw PS/2 lines from the device side plus the
// decoded Hack key code outputs towards the memory block.
interface ps2_keyboard_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keyboard;
   logic       key_event;
   logic       frame_error;

   modport master (
      output ps2_clk,
      output ps2_data,
      input  keyboard,
      input  key_event,
      input  frame_error
   );

   modport slave (
      input  ps2_clk,
      input  ps2_data,
      output keyboard,
      output key_event,
      output frame_error
   );
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 set-2 keyboard receiver and Hack key-code decoder: frames bytes off the
// PS/2 lines, tracks E0/F0 prefixes and shift, and holds the current key code.
module ps2_keyboard #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic           clk,
   input  logic           reset,
   ps2_keyboard_if.slave  kbd_if
);

   localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   rx_state_e        state_q;
   logic [1:0]       clk_sync_q;
   logic [1:0]       data_sync_q;
   logic             clk_prev_q;
   logic [2:0]       bit_cnt_q;
   logic [7:0]       rx_sr_q;
   logic             parity_q;
   logic [TMO_W-1:0] tmo_cnt_q;
   logic             byte_valid_q;
   logic             timeout_q;
   logic             frame_error_q;

   logic             ext_q;
   logic             brk_q;
   logic             shift_q;
   logic [8:0]       held_q;
   logic [7:0]       keyboard_q;
   logic             key_event_q;

   logic             fall_c;
   logic             bit_c;
   logic [7:0]       map_c;

   // Scan code to Hack code; 0 means unmapped.
   function automatic logic [7:0] map_key(input logic ext, input logic [7:0] sc,
                                          input logic sh);
      logic [7:0] code;
      logic       letter;
      code   = 8'd0;
      letter = 1'b0;
      if (ext) begin
         case (sc)
            8'h6B:   code = 8'd130;
            8'h75:   code = 8'd131;
            8'h74:   code = 8'd132;
            8'h72:   code = 8'd133;
            8'h6C:   code = 8'd134;
            8'h69:   code = 8'd135;
            8'h7D:   code = 8'd136;
            8'h7A:   code = 8'd137;
            8'h70:   code = 8'd138;
            8'h71:   code = 8'd139;
            default: code = 8'd0;
         endcase
      end else begin
         letter = 1'b1;
         case (sc)
            8'h1C:   code = 8'd97;
            8'h32:   code = 8'd98;
            8'h21:   code = 8'd99;
            8'h23:   code = 8'd100;
            8'h24:   code = 8'd101;
            8'h2B:   code = 8'd102;
            8'h34:   code = 8'd103;
            8'h33:   code = 8'd104;
            8'h43:   code = 8'd105;
            8'h3B:   code = 8'd106;
            8'h42:   code = 8'd107;
            8'h4B:   code = 8'd108;
            8'h3A:   code = 8'd109;
            8'h31:   code = 8'd110;
            8'h44:   code = 8'd111;
            8'h4D:   code = 8'd112;
            8'h15:   code = 8'd113;
            8'h2D:   code = 8'd114;
            8'h1B:   code = 8'd115;
            8'h2C:   code = 8'd116;
            8'h3C:   code = 8'd117;
            8'h2A:   code = 8'd118;
            8'h1D:   code = 8'd119;
            8'h22:   code = 8'd120;
            8'h35:   code = 8'd121;
            8'h1A:   code = 8'd122;
            default: letter = 1'b0;
         endcase
         if (!letter) begin
            case (sc)
               8'h45:   code = 8'd48;
               8'h16:   code = 8'd49;
               8'h1E:   code = 8'd50;
               8'h26:   code = 8'd51;
               8'h25:   code = 8'd52;
               8'h2E:   code = 8'd53;
               8'h36:   code = 8'd54;
               8'h3D:   code = 8'd55;
               8'h3E:   code = 8'd56;
               8'h46:   code = 8'd57;
               8'h29:   code = 8'd32;
               8'h5A:   code = 8'd128;
               8'h66:   code = 8'd129;
               8'h76:   code = 8'd140;
               8'h05:   code = 8'd141;
               8'h06:   code = 8'd142;
               8'h04:   code = 8'd143;
               8'h0C:   code = 8'd144;
               8'h03:   code = 8'd145;
               8'h0B:   code = 8'd146;
               8'h83:   code = 8'd147;
               8'h0A:   code = 8'd148;
               8'h01:   code = 8'd149;
               8'h09:   code = 8'd150;
               8'h78:   code = 8'd151;
               8'h07:   code = 8'd152;
               default: code = 8'd0;
            endcase
         end else if (sh) begin
            code = code - 8'd32;
         end
      end
      return code;
   endfunction

   assign fall_c = clk_prev_q & ~clk_sync_q[1];
   assign bit_c  = data_sync_q[1];
   assign map_c  = map_key(ext_q, rx_sr_q, shift_q);

   // Two-flop synchronizers plus the previous-cycle clock for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], kbd_if.ps2_clk};
         data_sync_q <= {data_sync_q[0], kbd_if.ps2_data};
         clk_prev_q  <= clk_sync_q[1];
      end
   end

   // Frame receiver: start, 8 data LSB first, odd parity, stop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= 3'd0;
         rx_sr_q       <= 8'd0;
         parity_q      <= 1'b0;
         tmo_cnt_q     <= '0;
         byte_valid_q  <= 1'b0;
         timeout_q     <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         byte_valid_q  <= 1'b0;
         timeout_q     <= 1'b0;
         frame_error_q <= 1'b0;
         if (state_q != ST_IDLE && !fall_c && tmo_cnt_q == TMO_LAST) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
            timeout_q <= 1'b1;
         end else begin
            if (fall_c || state_q == ST_IDLE) begin
               tmo_cnt_q <= '0;
            end else begin
               tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
            if (fall_c) begin
               case (state_q)
                  ST_IDLE: begin
                     if (!bit_c) begin
                        state_q   <= ST_DATA;
                        bit_cnt_q <= 3'd0;
                     end else begin
                        frame_error_q <= 1'b1;
                     end
                  end
                  ST_DATA: begin
                     rx_sr_q <= {bit_c, rx_sr_q[7:1]};
                     if (bit_cnt_q == 3'd7) begin
                        state_q <= ST_PARITY;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                     end
                  end
                  ST_PARITY: begin
                     parity_q <= bit_c;
                     state_q  <= ST_STOP;
                  end
                  ST_STOP: begin
                     state_q <= ST_IDLE;
                     if (bit_c && (^{rx_sr_q, parity_q})) begin
                        byte_valid_q <= 1'b1;
                     end else begin
                        frame_error_q <= 1'b1;
                     end
                  end
                  default: state_q <= ST_IDLE;
               endcase
            end
         end
      end
   end

   // Byte decoder: prefix flags, shift tracking and held key code.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         shift_q     <= 1'b0;
         held_q      <= 9'd0;
         keyboard_q  <= 8'd0;
         key_event_q <= 1'b0;
      end else begin
         key_event_q <= 1'b0;
         if (timeout_q) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end else if (byte_valid_q) begin
            if (rx_sr_q == SC_EXT) begin
               ext_q <= 1'b1;
            end else if (rx_sr_q == SC_BRK) begin
               brk_q <= 1'b1;
            end else begin
               ext_q <= 1'b0;
               brk_q <= 1'b0;
               if (!ext_q && (rx_sr_q == SC_LSHIFT || rx_sr_q == SC_RSHIFT)) begin
                  shift_q <= ~brk_q;
               end else if (brk_q) begin
                  if ({ext_q, rx_sr_q} == held_q && keyboard_q != 8'd0) begin
                     keyboard_q  <= 8'd0;
                     key_event_q <= 1'b1;
                  end
               end else if (map_c != 8'd0) begin
                  held_q <= {ext_q, rx_sr_q};
                  if (map_c != keyboard_q) begin
                     keyboard_q  <= map_c;
                     key_event_q <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign kbd_if.keyboard    = keyboard_q;
   assign kbd_if.key_event   = key_event_q;
   assign kbd_if.frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: directed scenarios plus random key traffic checked
// against a table-driven model of the scan-code rules.
module tb_ps2_keyboard;
   localparam int unsigned TMO  = 100;
   localparam int          HALF = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   ps2_keyboard_if kif();

   ps2_keyboard #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk    (clk),
      .reset  (reset),
      .kbd_if (kif)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int ev_cnt = 0;
   int fe_cnt = 0;
   int last_ev_cyc = 0;
   int edge_cyc = 0;
   int ke_prev = 0;
   int fe_prev = 0;
   int kb_prev = 0;

   int m_kbd = 0;
   int m_held = 0;
   bit m_ext = 0;
   bit m_brk = 0;
   bit m_shift = 0;

   logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
      8'h3D, 8'h3E, 8'h46};
   logic [7:0] fkey_sc [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83,
      8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
   logic [7:0] ext_sc [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D,
      8'h7A, 8'h70, 8'h71};
   logic [7:0] misc_sc [4] = '{8'h29, 8'h5A, 8'h66, 8'h76};
   int         misc_code [4] = '{32, 128, 129, 140};
   logic [7:0] junk_sc [5] = '{8'hAA, 8'hFA, 8'hE1, 8'h14, 8'h77};

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model_map(input bit ext, input logic [7:0] sc, input bit sh);
      if (ext) begin
         for (int i = 0; i < 10; i++) if (ext_sc[i] == sc) return 130 + i;
         return -1;
      end
      for (int i = 0; i < 26; i++) if (letter_sc[i] == sc) return (sh ? 65 : 97) + i;
      for (int i = 0; i < 10; i++) if (digit_sc[i] == sc) return 48 + i;
      for (int i = 0; i < 12; i++) if (fkey_sc[i] == sc) return 141 + i;
      for (int i = 0; i < 4; i++) if (misc_sc[i] == sc) return misc_code[i];
      return -1;
   endfunction

   // Returns the number of key_event pulses the byte should cause.
   function automatic int model_byte(input logic [7:0] b);
      int code;
      int ev;
      ev = 0;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = !m_brk;
         else if (m_brk) begin
            if (m_kbd != 0 && m_held == ((int'(m_ext) << 8) | int'(b))) begin
               m_kbd = 0;
               ev = 1;
            end
         end else begin
            code = model_map(m_ext, b, m_shift);
            if (code >= 0) begin
               m_held = (int'(m_ext) << 8) | int'(b);
               if (code != m_kbd) begin
                  m_kbd = code;
                  ev = 1;
               end
            end
         end
         m_ext = 0;
         m_brk = 0;
      end
      return ev;
   endfunction

   function automatic void model_reset();
      m_kbd = 0; m_held = 0; m_ext = 0; m_brk = 0; m_shift = 0;
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!reset) begin
         if (kif.key_event) begin
            ev_cnt++;
            last_ev_cyc = cyc;
            check("ke_single", ke_prev, 0);
         end
         if (kif.frame_error) begin
            fe_cnt++;
            check("fe_single", fe_prev, 0);
         end
         if (kif.key_event || int'(kif.keyboard) != kb_prev)
            check("ke_on_change", int'(kif.key_event), int'(int'(kif.keyboard) != kb_prev));
      end
      ke_prev = int'(kif.key_event);
      fe_prev = int'(kif.frame_error);
      kb_prev = int'(kif.keyboard);
   end

   task automatic ps2_bit(input bit v);
      kif.ps2_data = v;
      repeat (HALF) @(negedge clk);
      kif.ps2_clk = 1'b0;
      edge_cyc = cyc;
      repeat (HALF) @(negedge clk);
      kif.ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad_par);
      ps2_bit(!bad_stop);
   endtask

   task automatic send_partial(input logic [7:0] b, input int n);
      ps2_bit(1'b0);
      for (int i = 0; i < n; i++) ps2_bit(b[i]);
   endtask

   task automatic xfer(input logic [7:0] b, input string tag);
      int e0;
      int f0;
      int exp_ev;
      e0 = ev_cnt;
      f0 = fe_cnt;
      send_frame(b, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      exp_ev = model_byte(b);
      check({tag, "_kbd"}, int'(kif.keyboard), m_kbd);
      check({tag, "_ev"}, ev_cnt - e0, exp_ev);
      check({tag, "_fe"}, fe_cnt - f0, 0);
   endtask

   task automatic bad_frame(input logic [7:0] b, input bit par, input bit stp, input string tag);
      int e0;
      int f0;
      e0 = ev_cnt;
      f0 = fe_cnt;
      send_frame(b, par, stp);
      repeat (8) @(negedge clk);
      check({tag, "_kbd"}, int'(kif.keyboard), m_kbd);
      check({tag, "_ev"}, ev_cnt - e0, 0);
      check({tag, "_fe"}, fe_cnt - f0, 1);
   endtask

   task automatic timeout_partial(input string tag);
      int f0;
      f0 = fe_cnt;
      send_partial(8'($urandom), 4);
      repeat (TMO + 5) @(negedge clk);
      m_ext = 0;
      m_brk = 0;
      check({tag, "_fe"}, fe_cnt - f0, 0);
   endtask

   task automatic make_random_key();
      int k;
      k = int'($urandom_range(0, 4));
      case (k)
         0: xfer(letter_sc[$urandom_range(0, 25)], "r_letter");
         1: xfer(digit_sc[$urandom_range(0, 9)], "r_digit");
         2: xfer(fkey_sc[$urandom_range(0, 11)], "r_fkey");
         3: xfer(misc_sc[$urandom_range(0, 3)], "r_misc");
         default: begin
            xfer(8'hE0, "r_e0");
            xfer(ext_sc[$urandom_range(0, 9)], "r_ext");
         end
      endcase
   endtask

   initial begin
      int f0;
      int r;
      kif.ps2_clk  = 1'b1;
      kif.ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_kbd", int'(kif.keyboard), 0);
      check("rst_ke", int'(kif.key_event), 0);
      check("rst_fe", int'(kif.frame_error), 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      xfer(8'h1C, "a_make");
      check("a_val", int'(kif.keyboard), 97);
      check("a_latency", last_ev_cyc - edge_cyc, 4);
      xfer(8'hF0, "a_f0");
      xfer(8'h1C, "a_break");
      check("a_released", int'(kif.keyboard), 0);

      xfer(8'h12, "sh_make");
      xfer(8'h1C, "A_make");
      check("A_val", int'(kif.keyboard), 65);
      xfer(8'hF0, "sh_f0");
      xfer(8'h12, "sh_break");
      check("A_held", int'(kif.keyboard), 65);
      xfer(8'hF0, "A_f0");
      xfer(8'h1C, "A_break");

      xfer(8'hE0, "up_e0");
      xfer(8'h75, "up_make");
      check("up_val", int'(kif.keyboard), 131);
      xfer(8'hF0, "kp8_f0");
      xfer(8'h75, "kp8_break");
      check("up_kept", int'(kif.keyboard), 131);
      xfer(8'hE0, "up_e0b");
      xfer(8'hF0, "up_f0");
      xfer(8'h75, "up_break");
      check("up_released", int'(kif.keyboard), 0);

      f0 = fe_cnt;
      ps2_bit(1'b1);
      repeat (8) @(negedge clk);
      check("bad_start_fe", fe_cnt - f0, 1);
      bad_frame(8'h1C, 1'b1, 1'b0, "bad_par");
      xfer(8'h29, "space");
      check("space_val", int'(kif.keyboard), 32);
      bad_frame(8'h1C, 1'b0, 1'b1, "bad_stop");

      timeout_partial("tmo");
      xfer(8'h5A, "enter");
      check("enter_val", int'(kif.keyboard), 128);
      xfer(8'hE0, "tmo_e0");
      timeout_partial("tmo_pfx");
      xfer(8'h75, "tmo_kp8");
      check("tmo_pfx_val", int'(kif.keyboard), 128);
      xfer(8'h5A, "enter_rpt");

      xfer(8'h29, "space2");
      send_partial(8'h1C, 4);
      kif.ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      kif.ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_kbd", int'(kif.keyboard), 0);
      check("midrst_ke", int'(kif.key_event), 0);
      model_reset();
      repeat (HALF) @(negedge clk);
      kif.ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      xfer(8'h66, "bksp");
      check("bksp_val", int'(kif.keyboard), 129);

      for (int it = 0; it < 50; it++) begin
         r = int'($urandom_range(0, 99));
         if (r < 40) make_random_key();
         else if (r < 60) begin
            if (m_held[8]) xfer(8'hE0, "rb_e0");
            xfer(8'hF0, "rb_f0");
            xfer(8'(m_held), "rb_code");
         end else if (r < 70) begin
            if ($urandom_range(0, 1) == 1) xfer(8'hF0, "rs_f0");
            xfer(($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59, "rs_shift");
         end else if (r < 80) xfer(8'($urandom_range(0, 255)), "r_byte");
         else if (r < 88) xfer(junk_sc[$urandom_range(0, 4)], "r_junk");
         else if (r < 95) begin
            if ($urandom_range(0, 1) == 1) bad_frame(8'($urandom), 1'b1, 1'b0, "r_badpar");
            else bad_frame(8'($urandom), 1'b0, 1'b1, "r_badstop");
         end else timeout_partial("r_tmo");
      end

      repeat (10) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 50000; clk cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-002 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ps2_clk  input  1  raw PS/2 clock from the device, asynchronous to clk.
REQ-005 ps2_data  input  1  raw PS/2 data from the device, asynchronous to clk.
REQ-006 keyboard  output  8  Hack key code of the currently held key, 0 when none; drives the memory block's keyboard input.
REQ-007 key_event  output  1  one-cycle pulse in the cycle keyboard takes a new value.
REQ-008 frame_error  output  1  one-cycle pulse when a frame is discarded for bad start, parity or stop bit.

Function
REQ-009 ps2_clk and ps2_data shall each pass through a 2-flop synchronizer before any use.
REQ-010 A falling edge is a synchronized ps2_clk of 1 in the previous cycle and 0 in the current cycle; data shall be sampled only in that cycle.
REQ-011 Receiver FSM states: IDLE, DATA, PARITY, STOP.
REQ-012 IDLE: on a falling edge with data=0, go to DATA with bit count 0; with data=1, stay in IDLE and pulse frame_error.
REQ-013 DATA: shift 8 bits in, LSB first, then go to PARITY; PARITY: store the bit, go to STOP.
REQ-014 STOP: on a falling edge go to IDLE; accept the byte when stop=1 and the 8 data bits plus parity contain an odd number of ones; otherwise discard it and pulse frame_error.
REQ-015 Timing: an accepted byte raises an internal byte_valid in cycle N+1, where N is the stop-sample cycle; keyboard and key_event update in cycle N+2.
REQ-016 In DATA, PARITY or STOP, TIMEOUT_CYCLES consecutive cycles with no falling edge shall return the FSM to IDLE, discard the partial frame and clear both prefix flags, without pulsing frame_error.
REQ-017 Decoder flags: ext is set by byte 0xE0; brk is set by byte 0xF0; the next non-prefix byte consumes both and clears them.
REQ-018 shift flag: set by make of 0x12 or 0x59 and cleared by their break; keyboard shall not change.
REQ-019 Mapping, non-extended: 0x1C..0x1A letters map to ASCII 97-122 when shift=0 and 65-90 when shift=1; digit row to 48-57; 0x29 to 32; 0x5A to 128; 0x66 to 129; 0x76 to 140; F1-F12 to 141-152.
REQ-020 Mapping, extended: 0x6B→130, 0x75→131, 0x74→132, 0x72→133, 0x6C→134, 0x69→135, 0x7D→136, 0x7A→137, 0x70→138, 0x71→139.
REQ-021 The mapped code shall be latched when the make is decoded; shift changes after the make shall not alter the held value.
REQ-022 Make of a mapped key: keyboard becomes its code and key_event pulses, even if keyboard was already nonzero; a repeated make with an identical code shall not pulse key_event.
REQ-023 Break of the scan code (with ext) that produced the current keyboard value: keyboard becomes 0 and key_event pulses; breaks of any other key are ignored.
REQ-024 Unmapped scan codes shall be ignored, including 0xE1 sequences and 0xAA/0xFA device responses.
REQ-025 key_event and frame_error shall never be high for more than one consecutive cycle.

Reset
REQ-026 While reset is high: FSM IDLE; bit count, shift register, ext, brk, shift, stored scan code, timeout counter, synchronizers (to 1) and byte_valid all cleared.
REQ-027 Output reset values: keyboard=0, key_event=0, frame_error=0.
REQ-028 Reset asserted mid-frame shall discard the partial frame; the first falling edge after release is treated as a potential start bit.

Verification
REQ-029 Frame 0x1C, shift clear → keyboard=97 at N+2 and key_event pulses exactly once; then F0,1C → keyboard=0 with one key_event pulse.
REQ-030 Frames 12, 1C, F0 12 → keyboard=65 after 0x1C, and stays 65 after the shift break.
REQ-031 Frames E0,75 → keyboard=131; then F0,75 without E0 → keyboard stays 131; then E0,F0,75 → keyboard=0.
REQ-032 Frame 0x1C sent with even parity → frame_error pulses once and keyboard is unchanged; the next good 0x29 → keyboard=32.
REQ-033 Stop after 4 data bits for TIMEOUT_CYCLES+5 cycles, then send a full 0x5A → no frame_error, keyboard=128.
REQ-034 Assert reset during the 5th data bit of 0x1C while keyboard=32 → keyboard=0 immediately; after release, a full 0x66 → keyboard=129.
